// File: rtl/scroll_ctrl_pkg.sv
// Shared types and constants for the scrolling 7-segment message sequencer.
package scroll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam int          NDIG       = 4;
  localparam logic [3:0]  AN_ALL_OFF = 4'b1111;

endpackage

// File: rtl/scroll_ctrl_mod_counter.sv
// Modulo-MOD counter with enable and synchronous clear; o_wrap flags the enabled terminal count.
module mod_counter #(
  parameter int MOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);

  localparam int W = (MOD > 2) ? $clog2(MOD) : 1;

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(MOD - 1));
  assign o_wrap = i_en && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/scroll_ctrl.sv
// Scroll sequencer: run/pause/step/stop FSM, message position counter and 4-digit anode scan.
// Handshake: start/pause/step/stop are single-cycle pulses, no ready; each is acted on in the cycle it is high.
module scroll_ctrl
  import scroll_ctrl_pkg::*;
#(
  parameter int TICK_CYCLES    = 8388608,
  parameter int REFRESH_CYCLES = 65536,
  parameter int MSG_LEN        = 16,
  parameter int POS_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             step,
  input  logic             stop,
  input  logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             step_tick,
  output logic             running,
  output logic [3:0]       an_n,
  output logic [POS_W-1:0] char_idx,
  output state_t           state_dbg
);

  state_t           r_state;
  logic [POS_W-1:0] r_pos;
  logic             r_step_tick;
  logic             r_running;
  logic [1:0]       r_digit;
  logic [3:0]       r_an_n;
  logic [POS_W-1:0] r_char_idx;

  logic             w_tick;
  logic             w_ref_wrap;
  logic             w_presc_clr;
  logic             w_adv;
  logic [POS_W-1:0] w_pos_nxt;
  logic [1:0]       w_digit_nxt;
  logic [POS_W:0]   w_sum;
  logic [POS_W-1:0] w_char_nxt;

  // Prescaler only counts in RUN, so PAUSED keeps the partial period.
  assign w_presc_clr = stop || (r_state == ST_IDLE);

  mod_counter #(.MOD(TICK_CYCLES)) u_presc (
    .clk   (clk),
    .rst   (reset),
    .i_en  (r_state == ST_RUN),
    .i_clr (w_presc_clr),
    .o_wrap(w_tick)
  );

  mod_counter #(.MOD(REFRESH_CYCLES)) u_refresh (
    .clk   (clk),
    .rst   (reset),
    .i_en  (1'b1),
    .i_clr (1'b0),
    .o_wrap(w_ref_wrap)
  );

  // A tick still advances on the same edge RUN leaves for PAUSED; stop overrides everything.
  assign w_adv = !stop &&
                 (((r_state == ST_RUN) && w_tick) ||
                  ((r_state == ST_PAUSED) && !pause && step));

  always_comb begin
    w_pos_nxt = r_pos;
    if (stop || (r_state == ST_IDLE)) begin
      w_pos_nxt = '0;
    end else if (w_adv) begin
      if (dir) begin
        w_pos_nxt = (r_pos == '0) ? POS_W'(MSG_LEN - 1) : r_pos - POS_W'(1);
      end else begin
        w_pos_nxt = (r_pos == POS_W'(MSG_LEN - 1)) ? '0 : r_pos + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else if (stop) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (pause) begin
            r_state   <= ST_PAUSED;
            r_running <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (pause) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos       <= '0;
      r_step_tick <= 1'b0;
    end else begin
      r_pos       <= w_pos_nxt;
      r_step_tick <= w_adv;
    end
  end

  // char_idx is built from the next pos and next digit so it always matches the lit anode.
  assign w_digit_nxt = w_ref_wrap ? r_digit + 2'd1 : r_digit;
  assign w_sum       = {1'b0, w_pos_nxt} + (POS_W + 1)'(w_digit_nxt);
  assign w_char_nxt  = (w_sum >= (POS_W + 1)'(MSG_LEN)) ?
                       POS_W'(w_sum - (POS_W + 1)'(MSG_LEN)) : POS_W'(w_sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit    <= 2'd0;
      r_an_n     <= 4'b1110;
      r_char_idx <= '0;
    end else begin
      r_digit    <= w_digit_nxt;
      r_an_n     <= AN_ALL_OFF ^ (4'b0001 << w_digit_nxt);
      r_char_idx <= w_char_nxt;
    end
  end

  assign pos       = r_pos;
  assign step_tick = r_step_tick;
  assign running   = r_running;
  assign an_n      = r_an_n;
  assign char_idx  = r_char_idx;
  assign state_dbg = r_state;

endmodule
